// File: rtl/hazard_flush_unit_pkg.sv
// hazard_flush_unit_pkg: FSM encoding and default widths for the hazard/flush controller
package hazard_flush_unit_pkg;
    typedef enum logic {HFU_IDLE = 1'b0, HFU_BUSY = 1'b1} hfu_state_e;
    localparam int PC_WIDTH_DEF = 32;
    localparam int REG_ADDR_WIDTH_DEF = 5;
    localparam int MC_LAT_WIDTH_DEF = 6;
    localparam int CNT_WIDTH_DEF = 16;
endpackage

// File: rtl/hazard_flush_unit_if.sv
// hazard_flush_unit_if: pipeline status in, hold/flush/redirect controls out
interface hazard_flush_unit_if
    import hazard_flush_unit_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int MC_LAT_WIDTH = MC_LAT_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) ();
    logic [PC_WIDTH-1:0] id_pc, ex_target_pc, ex_pc_plus4, redirect_pc;
    logic ex_valid, ex_branch, ex_jump, ex_taken, ex_mem_r;
    logic [REG_ADDR_WIDTH-1:0] ex_rd, id_rs1, id_rs2;
    logic id_rs1_used, id_rs2_used, mc_start, ext_stall, cnt_clr;
    logic [MC_LAT_WIDTH-1:0] mc_lat;
    logic pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, ex_mem_flush, redirect_valid;
    logic [CNT_WIDTH-1:0] mispredict_cnt;
    modport master (
        output id_pc, ex_valid, ex_branch, ex_jump, ex_taken, ex_target_pc, ex_pc_plus4,
               ex_mem_r, ex_rd, id_rs1, id_rs2, id_rs1_used, id_rs2_used, mc_start, mc_lat,
               ext_stall, cnt_clr,
        input  pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, ex_mem_flush,
               redirect_valid, redirect_pc, mispredict_cnt
    );
    modport slave (
        input  id_pc, ex_valid, ex_branch, ex_jump, ex_taken, ex_target_pc, ex_pc_plus4,
               ex_mem_r, ex_rd, id_rs1, id_rs2, id_rs1_used, id_rs2_used, mc_start, mc_lat,
               ext_stall, cnt_clr,
        output pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, ex_mem_flush,
               redirect_valid, redirect_pc, mispredict_cnt
    );
endinterface

// File: rtl/hazard_flush_unit_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking precedence
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (clr) q <= '0;
        else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/hazard_flush_unit.sv
// hazard_flush_unit: mispredict redirect, load-use bubbles, multi-cycle EX freeze and memory stall
module hazard_flush_unit
    import hazard_flush_unit_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int MC_LAT_WIDTH = MC_LAT_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input logic clk,
    input logic rst,
    hazard_flush_unit_if.slave hif
);
    hfu_state_e state, state_nx;
    logic [MC_LAT_WIDTH-1:0] cnt, cnt_nx;
    logic [PC_WIDTH-1:0] correct_pc;
    logic redir, lu, mc_go, mc_stall, redir_win;

    assign correct_pc = (hif.ex_jump || hif.ex_taken) ? hif.ex_target_pc : hif.ex_pc_plus4;
    assign redir = hif.ex_valid && (hif.ex_branch || hif.ex_jump) && (hif.id_pc != correct_pc);
    assign lu = hif.ex_valid && hif.ex_mem_r && (hif.ex_rd != '0) &&
                ((hif.id_rs1_used && hif.id_rs1 == hif.ex_rd) || (hif.id_rs2_used && hif.id_rs2 == hif.ex_rd));
    assign mc_go = (state == HFU_IDLE) && hif.ex_valid && hif.mc_start &&
                   (hif.mc_lat >= MC_LAT_WIDTH'(2)) && !hif.ext_stall;
    assign mc_stall = mc_go || (state == HFU_BUSY && cnt > MC_LAT_WIDTH'(1));
    assign redir_win = !rst && !hif.ext_stall && !mc_stall && redir;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= HFU_IDLE;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
        end

    // BUSY counts down the remaining EX cycles; an external stall freezes it
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        if (mc_go) begin
            state_nx = HFU_BUSY;
            cnt_nx = hif.mc_lat - 1'b1;
        end else if (state == HFU_BUSY && !hif.ext_stall) begin
            cnt_nx = cnt - 1'b1;
            state_nx = (cnt == MC_LAT_WIDTH'(1)) ? HFU_IDLE : HFU_BUSY;
        end
    end

    always_comb begin
        hif.pc_hold = 1'b0;
        hif.if_id_hold = 1'b0;
        hif.id_ex_hold = 1'b0;
        hif.if_id_flush = 1'b0;
        hif.id_ex_flush = 1'b0;
        hif.ex_mem_flush = 1'b0;
        hif.redirect_valid = 1'b0;
        hif.redirect_pc = '0;
        if (!rst) begin
            if (hif.ext_stall || mc_stall) begin
                hif.pc_hold = 1'b1;
                hif.if_id_hold = 1'b1;
                hif.id_ex_hold = 1'b1;
                hif.ex_mem_flush = !hif.ext_stall;
            end else if (redir) begin
                hif.if_id_flush = 1'b1;
                hif.id_ex_flush = 1'b1;
                hif.redirect_valid = 1'b1;
                hif.redirect_pc = correct_pc;
            end else if (lu) begin
                hif.pc_hold = 1'b1;
                hif.if_id_hold = 1'b1;
                hif.id_ex_flush = 1'b1;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
        .clk(clk),
        .rst(rst),
        .inc(redir_win),
        .clr(hif.cnt_clr),
        .q(hif.mispredict_cnt)
    );
endmodule

// File: tb/tb_hazard_flush_unit.sv
// tb_hazard_flush_unit: directed scoreboard bench for hazard_flush_unit (2-bit mispredict counter)
module tb_hazard_flush_unit;
    localparam logic [6:0] C0 = 7'b0000000;
    localparam logic [6:0] EXS = 7'b1110000;
    localparam logic [6:0] MCS = 7'b1110010;
    localparam logic [6:0] RD = 7'b0001101;
    localparam logic [6:0] LU = 7'b1100100;

    typedef struct {
        string tag;
        logic [6:0] ctl;
        logic [31:0] rpc;
        logic [1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_flush_unit_if #(.PC_WIDTH(32), .REG_ADDR_WIDTH(5), .MC_LAT_WIDTH(6), .CNT_WIDTH(2)) hif ();

    hazard_flush_unit #(.PC_WIDTH(32), .REG_ADDR_WIDTH(5), .MC_LAT_WIDTH(6), .CNT_WIDTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .hif(hif)
    );

    task automatic clear_in();
        hif.id_pc = '0;
        hif.ex_valid = 0;
        hif.ex_branch = 0;
        hif.ex_jump = 0;
        hif.ex_taken = 0;
        hif.ex_target_pc = '0;
        hif.ex_pc_plus4 = '0;
        hif.ex_mem_r = 0;
        hif.ex_rd = '0;
        hif.id_rs1 = '0;
        hif.id_rs2 = '0;
        hif.id_rs1_used = 0;
        hif.id_rs2_used = 0;
        hif.mc_start = 0;
        hif.mc_lat = '0;
        hif.ext_stall = 0;
        hif.cnt_clr = 0;
    endtask

    task automatic branch(input logic taken, input logic [31:0] tgt, input logic [31:0] p4, input logic [31:0] idpc);
        hif.ex_valid = 1;
        hif.ex_branch = 1;
        hif.ex_taken = taken;
        hif.ex_target_pc = tgt;
        hif.ex_pc_plus4 = p4;
        hif.id_pc = idpc;
    endtask

    task automatic step(input string tag, input logic [6:0] ctl, input logic [31:0] rpc, input logic [1:0] cnt);
        exp_t e;
        logic [6:0] oc;
        sb.push_back('{tag, ctl, rpc, cnt});
        @(negedge clk);
        e = sb.pop_front();
        oc = {hif.pc_hold, hif.if_id_hold, hif.id_ex_hold, hif.if_id_flush, hif.id_ex_flush,
              hif.ex_mem_flush, hif.redirect_valid};
        checks++;
        assert ({oc, hif.redirect_pc, hif.mispredict_cnt} === {e.ctl, e.rpc, e.cnt})
        else begin
            failures++;
            $error("FAIL %s: got ctl=%b pc=%h cnt=%0d, want ctl=%b pc=%h cnt=%0d",
                   e.tag, oc, hif.redirect_pc, hif.mispredict_cnt, e.ctl, e.rpc, e.cnt);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1;
        clear_in();
        branch(1, 32'h40, 32'h14, 32'h14);
        hif.ext_stall = 1;
        step("reset_forces_zero", C0, 0, 0);
        rst = 0;
        clear_in();
        branch(1, 32'h40, 32'h14, 32'h40);
        step("correct_pred", C0, 0, 0);
        branch(1, 32'h40, 32'h14, 32'h14);
        step("mispredict_taken", RD, 32'h40, 0);
        branch(0, 32'h40, 32'h14, 32'h40);
        step("mispredict_nottaken", RD, 32'h14, 1);
        clear_in();
        step("idle_cnt2", C0, 0, 2);
        hif.ex_valid = 1;
        hif.ex_mem_r = 1;
        hif.ex_rd = 5;
        hif.id_rs2 = 5;
        hif.id_rs2_used = 1;
        step("load_use", LU, 0, 2);
        hif.ex_rd = 0;
        hif.id_rs2 = 0;
        step("load_use_x0", C0, 0, 2);
        hif.ex_rd = 5;
        hif.id_rs2 = 5;
        branch(1, 32'h80, 32'h14, 32'h14);
        step("redir_over_lu", RD, 32'h80, 2);
        clear_in();
        branch(1, 32'h80, 32'h14, 32'h14);
        hif.ext_stall = 1;
        step("redir_under_stall", EXS, 0, 3);
        hif.ext_stall = 0;
        step("mispredict_4", RD, 32'h80, 3);
        step("mispredict_5", RD, 32'h80, 3);
        clear_in();
        step("saturated", C0, 0, 3);
        branch(1, 32'h80, 32'h14, 32'h14);
        hif.cnt_clr = 1;
        step("clr_with_redir", RD, 32'h80, 3);
        clear_in();
        step("cleared", C0, 0, 0);
        hif.ex_valid = 1;
        hif.mc_start = 1;
        hif.mc_lat = 4;
        step("mc4_c1", MCS, 0, 0);
        step("mc4_c2", MCS, 0, 0);
        step("mc4_c3", MCS, 0, 0);
        step("mc4_c4_release", C0, 0, 0);
        clear_in();
        step("mc4_after", C0, 0, 0);
        hif.ex_valid = 1;
        hif.mc_start = 1;
        hif.mc_lat = 1;
        step("mc_lat1", C0, 0, 0);
        hif.mc_lat = 0;
        step("mc_lat0", C0, 0, 0);
        hif.mc_lat = 4;
        step("mcx_c1", MCS, 0, 0);
        hif.mc_start = 0;
        step("mcx_c2", MCS, 0, 0);
        hif.ext_stall = 1;
        step("mcx_c3_ext", EXS, 0, 0);
        step("mcx_c4_ext", EXS, 0, 0);
        hif.ext_stall = 0;
        step("mcx_c5", MCS, 0, 0);
        step("mcx_c6_release", C0, 0, 0);
        clear_in();
        step("mcx_after", C0, 0, 0);
        hif.ex_valid = 1;
        hif.mc_start = 1;
        hif.mc_lat = 10;
        step("mc10_c1", MCS, 0, 0);
        step("mc10_c2", MCS, 0, 0);
        rst = 1;
        step("mc10_reset", C0, 0, 0);
        rst = 0;
        hif.mc_start = 0;
        step("post_reset_idle", C0, 0, 0);
        step("post_reset_idle2", C0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_flush_unit.md
# hazard_flush_unit

Parametrised pipeline hazard and flush controller for the five-stage RISC-V core. It replaces the flush logic in the ID-stage decoder. It resolves branch/jump mispredicts against the PC actually sitting in ID, inserts load-use bubbles, freezes the pipe for multi-cycle EX operations through a counter FSM, and honours an external memory stall. It sits beside the decoder and drives hold/flush controls for the PC and the IF/ID, ID/EX and EX/MEM pipeline registers.

## Interface
- `PC_WIDTH`, default 32: PC and target width.
- `REG_ADDR_WIDTH`, default 5: register-index width.
- `MC_LAT_WIDTH`, default 6: width of the multi-cycle latency field.
- `CNT_WIDTH`, default 16: width of the mispredict counter.

Ports:
- `clk`, in, 1: clock. Everything is sampled on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `id_pc`, in, PC_WIDTH: PC of the instruction in ID.
- `ex_valid`, `ex_branch`, `ex_jump`, `ex_taken`, in, 1 each: EX instruction is valid; it is a branch; it is a jump (JAL/JALR); branch-resolved taken.
- `ex_target_pc`, `ex_pc_plus4`, in, PC_WIDTH: resolved target and fall-through of the EX instruction.
- `ex_mem_r`, in, 1: EX instruction is a load.
- `ex_rd`, in, REG_ADDR_WIDTH: destination register of the EX instruction.
- `id_rs1`, `id_rs2`, in, REG_ADDR_WIDTH: source registers of the ID instruction.
- `id_rs1_used`, `id_rs2_used`, in, 1: the ID instruction reads rs1 / rs2.
- `mc_start`, in, 1: the EX instruction is multi-cycle.
- `mc_lat`, in, MC_LAT_WIDTH: total EX occupancy in cycles. 0 and 1 both mean single-cycle.
- `ext_stall`, in, 1: memory wait; the whole pipe freezes.
- `cnt_clr`, in, 1: synchronous clear of the mispredict counter.
- `pc_hold`, `if_id_hold`, `id_ex_hold`, out, 1 each: hold the corresponding register.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, out, 1 each: load a bubble into the corresponding register.
- `redirect_valid`, out, 1: the fetch PC must load `redirect_pc`.
- `redirect_pc`, out, PC_WIDTH: corrected fetch address.
- `mispredict_cnt`, out, CNT_WIDTH: saturating count of redirects.

## Operation
Signal definitions:
- `correct_pc` = `ex_jump | ex_taken` ? `ex_target_pc` : `ex_pc_plus4`.
- `redir` = `ex_valid & (ex_branch | ex_jump) & (id_pc != correct_pc)`. A correct prediction, where ID already holds `correct_pc`, causes no flush.
- `lu` = `ex_valid & ex_mem_r & ex_rd != 0 & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd))`.
- `mc_go` = `state == IDLE & ex_valid & mc_start & mc_lat >= 2 & !ext_stall`.
- `mc_stall` = `mc_go | (state == BUSY & cnt > 1)`.

Output priority, evaluated combinationally each cycle; unlisted outputs are 0:
1. `ext_stall`: `pc_hold`, `if_id_hold` and `id_ex_hold` = 1. No flush and no redirect.
2. `mc_stall`: the three holds = 1 and `ex_mem_flush` = 1.
3. `redir`: `if_id_flush` and `id_ex_flush` = 1, `redirect_valid` = 1, `redirect_pc` = `correct_pc`.
4. `lu`: `pc_hold` and `if_id_hold` = 1, `id_ex_flush` = 1.

When no rule fires, `redirect_pc` = 0.

State machine (states IDLE and BUSY) and counter:
- IDLE → BUSY on `mc_go`; load `cnt` = `mc_lat` − 1.
- In BUSY with `!ext_stall`: `cnt` decrements. When `cnt == 1`, return to IDLE; that cycle is unstalled and the operation completes.
- In BUSY with `ext_stall`: `cnt` and state freeze.
- `mc_start` is ignored in BUSY.
- `cnt` is MC_LAT_WIDTH bits.
- `mispredict_cnt` increments on each cycle where `redir` wins priority, saturating at all ones. `cnt_clr` takes precedence over the increment.

Reset and boundaries:
- While `rst` is high: state = IDLE, `cnt` = 0, `mispredict_cnt` = 0, and every output is forced to 0.
- Reset asserted mid-BUSY aborts the operation; the pipe restarts from IDLE.
- `redir` together with `lu`: only the redirect fires, because the ID instruction is wrong-path.
- `redir` together with `ext_stall`: nothing fires. The EX instruction is held and re-evaluated when the stall clears.

## Timing
- Flush, hold and redirect outputs are combinational from the inputs and the registered state, with zero-cycle latency and no combinational path from `rst` except the force-to-0.
- A multi-cycle operation occupies EX for exactly `mc_lat` cycles, plus any `ext_stall` cycles. Stall is asserted on the first `mc_lat` − 1 of those cycles.
- `redirect_valid` is a single-cycle pulse per mispredicted instruction.
- `mispredict_cnt` updates on the edge after the redirect.
- All outputs are glitch-sensitive: implement them as `always @(*)` with full default assignment. Do not use a chained conditional assign.

## Structure
- Add to the shared `SYSTEM_DEF.vh`:
  - state encodings `HFU_IDLE` and `HFU_BUSY`;
  - `PC_WIDTH` and `REG_ADDR_WIDTH` defaults.
- One sub-module, `sat_counter` (parameter WIDTH; inputs `inc`, `clr`), used for `mispredict_cnt`.
- The FSM, `cnt` and the priority network stay in `hazard_flush_unit`.

## Test plan
- Correct prediction: branch in EX, `ex_taken` = 1, `ex_target_pc` = 0x40, `id_pc` = 0x40 → all flushes 0, `redirect_valid` = 0, counter unchanged.
- Mispredict: same branch with `id_pc` = 0x14 → `if_id_flush` = `id_ex_flush` = 1, `redirect_pc` = 0x40, `mispredict_cnt` 0→1; repeated with `ex_taken` = 0, `ex_pc_plus4` = 0x14, `id_pc` = 0x40 → `redirect_pc` = 0x14.
- Load-use: `ex_mem_r` = 1, `ex_rd` = 5, `id_rs2` = 5, `id_rs2_used` = 1 → one cycle of `pc_hold`, `if_id_hold`, `id_ex_flush`; with `ex_rd` = 0 → no stall.
- Multi-cycle: `mc_start` with `mc_lat` = 4 → holds asserted 3 cycles, released on the 4th; `mc_lat` = 1 → no stall; `ext_stall` pulsed for 2 cycles mid-BUSY → total occupancy 6 cycles.
- Counter saturation (CNT_WIDTH = 2): 5 mispredicts → count reads 3; `cnt_clr` coincident with a mispredict → 0.
- Reset mid-BUSY with `mc_lat` = 10 at cycle 3 → all outputs 0 immediately; after release with `mc_start` = 0 → no stall.
